// File: rtl/logic_op_pipe_pkg.sv
// Shared opcode encoding and widths for the pipelined bitwise logic unit.
package logic_op_pipe_pkg;

   localparam int LOGIC_OP_W = 3;

   typedef enum logic [LOGIC_OP_W-1:0] {
      OP_AND   = 3'd0,
      OP_OR    = 3'd1,
      OP_XOR   = 3'd2,
      OP_NAND  = 3'd3,
      OP_NOR   = 3'd4,
      OP_XNOR  = 3'd5,
      OP_NOTA  = 3'd6,
      OP_PASSA = 3'd7
   } logic_op_e;

endpackage

// File: rtl/logic_array.sv
// Combinational bitwise gate array: one result word per opcode, B unused for NOTA/PASSA.
module logic_array
   import logic_op_pipe_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic_op_e        op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   // NOTE: assigning a default before the case keeps the block free of inferred latches.
   always_comb begin
      y = '0;
      case (op)
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_XOR:   y = a ^ b;
         OP_NAND:  y = ~(a & b);
         OP_NOR:   y = ~(a | b);
         OP_XNOR:  y = ~(a ^ b);
         OP_NOTA:  y = ~a;
         OP_PASSA: y = a;
      endcase
   end

endmodule

// File: rtl/logic_op_pipe.sv
// Two-stage valid/ready pipeline around logic_array: S1 holds operands, S2 holds result and flags.
module logic_op_pipe
   import logic_op_pipe_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LOGIC_OP_W-1:0] in_op,
   input  logic [WIDTH-1:0]      in_a,
   input  logic [WIDTH-1:0]      in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_res,
   output logic                  out_zero,
   output logic                  out_ones,
   output logic                  out_par,
   output logic [CNT_W-1:0]      op_count
);

   logic             s1_valid_q, s1_valid_d;
   logic_op_e        s1_op_q;
   logic [WIDTH-1:0] s1_a_q, s1_b_q;

   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d;
   logic             ones_q, ones_d;
   logic             par_q, par_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             s2_adv;
   logic             in_fire;
   logic             out_fire;
   logic [WIDTH-1:0] y;

   logic_array #(.WIDTH(WIDTH)) u_array (
      .op (s1_op_q),
      .a  (s1_a_q),
      .b  (s1_b_q),
      .y  (y)
   );

   // S1 may refill on the same edge it drains, so there is no bubble at full throughput.
   assign s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
   assign in_ready = !s1_valid_q || s2_adv;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = s2_valid_q && out_ready;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      res_d      = res_q;
      zero_d     = zero_q;
      ones_d     = ones_q;
      par_d      = par_q;
      cnt_d      = cnt_q;

      if (in_fire)
         s1_valid_d = 1'b1;
      else if (s2_adv)
         s1_valid_d = 1'b0;

      if (s2_adv) begin
         s2_valid_d = 1'b1;
         res_d      = y;
         zero_d     = (y == '0);
         ones_d     = &y;
         par_d      = ^y;
      end else if (out_fire) begin
         s2_valid_d = 1'b0;
      end

      if (out_fire)
         cnt_d = cnt_q + CNT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         res_q      <= '0;
         zero_q     <= 1'b0;
         ones_q     <= 1'b0;
         par_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         res_q      <= res_d;
         zero_q     <= zero_d;
         ones_q     <= ones_d;
         par_q      <= par_d;
         cnt_q      <= cnt_d;
      end
   end

   // NOTE: operand registers are qualified by s1_valid_q, so they carry no reset.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         s1_op_q <= logic_op_e'(in_op);
         s1_a_q  <= in_a;
         s1_b_q  <= in_b;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_res   = res_q;
   assign out_zero  = zero_q;
   assign out_ones  = ones_q;
   assign out_par   = par_q;
   assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Self-checking bench for logic_op_pipe: vector table, scoreboard queue, stall/reset/wrap sequences.
module tb_logic_op_pipe;
   import logic_op_pipe_pkg::*;

   typedef struct packed {
      logic [15:0] res;
      logic        zero;
      logic        ones;
      logic        par;
   } exp_t;

   typedef struct {
      logic_op_e   op;
      logic [15:0] a;
      logic [15:0] b;
      exp_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_op = 3'd0;
   logic [15:0] in_a = '0;
   logic [15:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_res;
   logic        out_zero, out_ones, out_par;
   logic [15:0] op_count;

   logic        s_in_valid = 1'b0;
   logic        s_in_ready;
   logic [2:0]  s_in_op = 3'd0;
   logic [15:0] s_in_a = 16'h00FF;
   logic [15:0] s_in_b = 16'h0F0F;
   logic        s_out_valid;
   logic        s_out_ready = 1'b1;
   logic [15:0] s_out_res;
   logic        s_out_zero, s_out_ones, s_out_par;
   logic [1:0]  s_op_count;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   int   exp_cnt  = 0;
   logic rand_bp  = 1'b0;
   vec_t vecs[12];

   always #5 clk = ~clk;

   logic_op_pipe #(.WIDTH(16), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
      .out_zero(out_zero), .out_ones(out_ones), .out_par(out_par), .op_count(op_count)
   );

   logic_op_pipe #(.WIDTH(16), .CNT_W(2)) u_small (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op), .in_a(s_in_a), .in_b(s_in_b),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_res(s_out_res),
      .out_zero(s_out_zero), .out_ones(s_out_ones), .out_par(s_out_par), .op_count(s_op_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic_op_e op, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      case (op)
         OP_AND:   e.res = a & b;
         OP_OR:    e.res = a | b;
         OP_XOR:   e.res = a ^ b;
         OP_NAND:  e.res = ~(a & b);
         OP_NOR:   e.res = ~(a | b);
         OP_XNOR:  e.res = ~(a ^ b);
         OP_NOTA:  e.res = ~a;
         default:  e.res = a;
      endcase
      e.zero = (e.res == 16'h0000);
      e.ones = (e.res == 16'hFFFF);
      e.par  = ^e.res;
      return e;
   endfunction

   // Called at posedge+#1; returns at posedge+#1 after the transfer edge.
   task automatic send(input logic_op_e op, input logic [15:0] a, input logic [15:0] b, input exp_t e);
      in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
      @(negedge clk);
      check(name, sb.size(), 0);
   endtask

   // Scoreboard monitor: compares every accepted result and the running completion count.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_res_flags", {out_res, out_zero, out_ones, out_par}, e);
            check("op_count", op_count, exp_cnt);
            exp_cnt++;
         end
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      logic [15:0] held;
      int          k;
      int          cnt_before;
      int          n;
      vec_t        st[4];

      vecs[0]  = '{OP_NAND,  16'hFFFF, 16'h00FF, '{16'hFF00, 1'b0, 1'b0, 1'b0}};
      vecs[1]  = '{OP_AND,   16'hF0F0, 16'h0FF0, '{16'h00F0, 1'b0, 1'b0, 1'b0}};
      vecs[2]  = '{OP_OR,    16'hF0F0, 16'h0FF0, '{16'hFFF0, 1'b0, 1'b0, 1'b0}};
      vecs[3]  = '{OP_XOR,   16'hF0F0, 16'h0FF0, '{16'hFF00, 1'b0, 1'b0, 1'b0}};
      vecs[4]  = '{OP_NOR,   16'hF0F0, 16'h0FF0, '{16'h000F, 1'b0, 1'b0, 1'b0}};
      vecs[5]  = '{OP_AND,   16'hF0F0, 16'h0F0F, '{16'h0000, 1'b1, 1'b0, 1'b0}};
      vecs[6]  = '{OP_NOTA,  16'h0000, 16'h5A5A, '{16'hFFFF, 1'b0, 1'b1, 1'b0}};
      vecs[7]  = '{OP_XNOR,  16'h1234, 16'h1234, '{16'hFFFF, 1'b0, 1'b1, 1'b0}};
      vecs[8]  = '{OP_XOR,   16'h0001, 16'h0000, '{16'h0001, 1'b0, 1'b0, 1'b1}};
      vecs[9]  = '{OP_PASSA, 16'h8421, 16'hFFFF, '{16'h8421, 1'b0, 1'b0, 1'b0}};
      vecs[10] = '{OP_NOTA,  16'h0007, 16'h0000, '{16'hFFF8, 1'b0, 1'b0, 1'b1}};
      vecs[11] = '{OP_XNOR,  16'h00FF, 16'h0F0F, '{16'hF00F, 1'b0, 1'b0, 1'b0}};

      st[0] = '{OP_OR,   16'h1111, 16'h2222, '{16'h3333, 1'b0, 1'b0, 1'b0}};
      st[1] = '{OP_XOR,  16'hAAAA, 16'h5555, '{16'hFFFF, 1'b0, 1'b1, 1'b0}};
      st[2] = '{OP_AND,  16'hFFFF, 16'h1234, '{16'h1234, 1'b0, 1'b0, 1'b1}};
      st[3] = '{OP_NOR,  16'hFFFF, 16'h0000, '{16'h0000, 1'b1, 1'b0, 1'b0}};

      // Reset state
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_res", out_res, 0);
      check("rst_flags", {out_zero, out_ones, out_par}, 0);
      check("rst_op_count", op_count, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Single NAND with latency 2
      send(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].e);
      @(negedge clk); check("lat1_edge1", out_valid, 0);
      @(negedge clk); check("lat1_edge2", out_valid, 1);
      @(posedge clk); #1;

      // Back-to-back table vectors
      for (int i = 1; i < 12; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);
      drain("table_drain");
      check("table_count", op_count, 12);
      @(posedge clk); #1;

      // Stall: out_ready low for 5 cycles with in_valid held
      out_ready = 1'b0;
      k = 0;
      held = '0;
      in_op = st[0].op; in_a = st[0].a; in_b = st[0].b; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 2) held = out_res;
         if (in_ready) begin
            sb.push_back(st[k].e);
            k++;
         end
         @(posedge clk); #1;
         in_op = st[k].op; in_a = st[k].a; in_b = st[k].b;
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("stall_accepted", k, 2);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_res_hold", out_res, held);
      check("stall_out_res_val", held, 16'h3333);
      cnt_before = int'(op_count);
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain("stall_drain");
      check("stall_count", op_count, cnt_before + 2);

      // Random ops with random backpressure
      @(posedge clk); #1;
      rand_bp = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic_op_e   op;
         logic [15:0] a, b;
         op = logic_op_e'($urandom_range(0, 7));
         a  = 16'($urandom);
         b  = 16'($urandom);
         send(op, a, b, model(op, a, b));
      end
      rand_bp = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain("random_drain");

      // Async reset while both stages are full
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(st[2].op, st[2].a, st[2].b, st[2].e);
      send(st[3].op, st[3].a, st[3].b, st[3].e);
      @(negedge clk);
      check("full_in_ready", in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_op_count", op_count, 0);
      check("midrst_out_res", out_res, 0);
      sb.delete();
      exp_cnt = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(vecs[10].op, vecs[10].a, vecs[10].b, vecs[10].e);
      @(negedge clk); check("lat2_edge1", out_valid, 0);
      @(negedge clk); check("lat2_edge2", out_valid, 1);
      drain("post_rst_drain");
      check("post_rst_count", op_count, 1);

      // Counter wrap on the 2-bit-counter instance: 0,1,2,3,0 then 1
      @(posedge clk); #1;
      n = 0;
      s_in_op = OP_XOR;
      s_in_valid = 1'b1;
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         if (s_out_valid && s_out_ready) begin
            check("wrap_count", s_op_count, n % 4);
            n++;
         end
         @(posedge clk); #1;
         if (t == 4) s_in_valid = 1'b0;
      end
      check("wrap_completions", n, 5);
      check("wrap_final", s_op_count, 1);
      check("wrap_res", s_out_res, 16'h0FF0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
